booth_controller: RTL and testbench

- Control FSM for the radix-2 Booth multiplier datapath. Sits directly upstream of the datapath and drives all of its control strobes.
- Accepts a start request, sequences load, evaluate, add/subtract and shift for WIDTH iterations, then signals completion.
- Reads the datapath's registered {Q[0], Q_prev} pair to choose the operation for each iteration.
- Holds no operand data; it is pure sequencing plus an iteration counter.

---
 rtl/booth_pkg.sv | 60 ++++++
 rtl/booth_controller.sv | 117 +++++++++++
 tb/tb_booth_controller.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared types and constants for the radix-2 Booth controller.
//   booth_state_t : FSM state encoding (IDLE..DONE).
//   booth_ctrl_t  : bundle of registered control strobes, plus the decoder
//                   that maps a state onto that bundle (Moore outputs).
//   BOOTH_ADD/SUB : {Q[0], Q_prev} patterns that select add / subtract.
package booth_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      EVAL,
      ADD,
      SUB,
      SHIFT,
      DONE
   } booth_state_t;

   // {Q[0], Q_prev} = 01 -> end of a run of ones -> add M.
   // {Q[0], Q_prev} = 10 -> start of a run of ones -> subtract M.
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

   localparam int BOOTH_WIDTH = 8;

   typedef struct packed {
      logic load_m;
      logic load_q;
      logic reset_a;
      logic reset_qprev;
      logic add_m;
      logic subs_m;
      logic shift_all;
      logic busy;
      logic done;
   } booth_ctrl_t;

   // Moore output decode. Only ADD, SUB and SHIFT drive an arithmetic
   // strobe, and each drives exactly one, so the three are mutually
   // exclusive by construction.
   function automatic booth_ctrl_t booth_decode(input booth_state_t s);
      booth_ctrl_t c;
      c = '0;
      case (s)
         LOAD: begin
            c.load_m      = 1'b1;
            c.load_q      = 1'b1;
            c.reset_a     = 1'b1;
            c.reset_qprev = 1'b1;
         end
         ADD:     c.add_m     = 1'b1;
         SUB:     c.subs_m    = 1'b1;
         SHIFT:   c.shift_all = 1'b1;
         DONE:    c.done      = 1'b1;
         default: ;
      endcase
      c.busy = (s != IDLE);
      return c;
   endfunction

endpackage

// File: rtl/booth_controller.sv
// booth_controller: control FSM for a radix-2 Booth multiplier datapath.
//   Sequences LOAD, then WIDTH iterations of EVAL -> [ADD|SUB] -> SHIFT,
//   then DONE. All outputs are registered and decoded from the state.
// Ports:
//   clk, reset      - clock; asynchronous active-high reset
//   start           - multiply request, sampled only in IDLE
//   Qo_Qprev        - registered {Q[0], Q_prev} from the datapath
//   load_M, load_Q, reset_A, reset_Qprev, add_M, subs_M, shift_all
//                   - datapath control strobes
//   busy            - high from LOAD through DONE inclusive
//   done            - completion indication
//   ack             - only with BOOTH_DONE_HOLD_EN: releases DONE
// Build option BOOTH_DONE_HOLD_EN: hold DONE until ack is sampled high;
// without it DONE lasts a single cycle.
module booth_controller
   import booth_pkg::*;
#(
   parameter int WIDTH = BOOTH_WIDTH
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] Qo_Qprev,
`ifdef BOOTH_DONE_HOLD_EN
   input  logic       ack,
`endif
   output logic       load_M,
   output logic       load_Q,
   output logic       reset_A,
   output logic       reset_Qprev,
   output logic       add_M,
   output logic       subs_M,
   output logic       shift_all,
   output logic       busy,
   output logic       done
);

   // Counter must reach WIDTH after the last shift without wrapping.
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   booth_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   booth_ctrl_t      ctrl_q, ctrl_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = EVAL;
         end
         EVAL: begin
            // Qo_Qprev is a registered datapath output, stable all cycle.
            case (Qo_Qprev)
               BOOTH_SUB: state_d = SUB;
               BOOTH_ADD: state_d = ADD;
               default:   state_d = SHIFT;
            endcase
         end
         ADD:   state_d = SHIFT;
         SUB:   state_d = SHIFT;
         SHIFT: begin
            cnt_d = cnt_q + CNT_ONE;
            // Decision uses the pre-increment count.
            if (cnt_q == LAST_ITER) begin
               state_d = DONE;
            end else begin
               state_d = EVAL;
            end
         end
         DONE: begin
`ifdef BOOTH_DONE_HOLD_EN
            if (ack) begin
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
      // Outputs are decoded from the next state and registered alongside
      // it, so they are glitch-free yet still track the current state.
      ctrl_d = booth_decode(state_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign load_M      = ctrl_q.load_m;
   assign load_Q      = ctrl_q.load_q;
   assign reset_A     = ctrl_q.reset_a;
   assign reset_Qprev = ctrl_q.reset_qprev;
   assign add_M       = ctrl_q.add_m;
   assign subs_M      = ctrl_q.subs_m;
   assign shift_all   = ctrl_q.shift_all;
   assign busy        = ctrl_q.busy;
   assign done        = ctrl_q.done;

endmodule

// File: tb/tb_booth_controller.sv
// tb_booth_controller: drives booth_controller against a behavioural Booth
// datapath and checks latency, add/sub count, product and corner cases.
module tb_booth_controller;
   import booth_pkg::*;

   localparam int W = 8;
   localparam int MAX_CYC = 100;

   logic         clk;
   logic         reset;
   logic         start;
   logic [1:0]   Qo_Qprev;
`ifdef BOOTH_DONE_HOLD_EN
   logic         ack;
`endif
   logic         load_M, load_Q, reset_A, reset_Qprev;
   logic         add_M, subs_M, shift_all, busy, done;

   logic [W-1:0] num_1, num_2;
   logic [W-1:0] reg_a, reg_q, reg_m;
   logic         q_prev;

   int checks = 0;
   int errors = 0;

   booth_controller #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .Qo_Qprev    (Qo_Qprev),
`ifdef BOOTH_DONE_HOLD_EN
      .ack         (ack),
`endif
      .load_M      (load_M),
      .load_Q      (load_Q),
      .reset_A     (reset_A),
      .reset_Qprev (reset_Qprev),
      .add_M       (add_M),
      .subs_M      (subs_M),
      .shift_all   (shift_all),
      .busy        (busy),
      .done        (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural Booth datapath.
   always @(posedge clk) begin
      if (load_M)      reg_m  <= num_1;
      if (load_Q)      reg_q  <= num_2;
      if (reset_A)     reg_a  <= '0;
      if (reset_Qprev) q_prev <= 1'b0;
      if (add_M)       reg_a  <= reg_a + reg_m;
      if (subs_M)      reg_a  <= reg_a - reg_m;
      if (shift_all) begin
         reg_a  <= {reg_a[W-1], reg_a[W-1:1]};
         reg_q  <= {reg_a[0], reg_q[W-1:1]};
         q_prev <= reg_q[0];
      end
   end
   assign Qo_Qprev = {reg_q[0], q_prev};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] all_outs();
      return {load_M, load_Q, reset_A, reset_Qprev, add_M, subs_M, shift_all, busy, done};
   endfunction

   // Runs one multiply from IDLE. lat = cycles from accepting edge to the
   // cycle done is seen (-1 on timeout). Optionally pulses start at cycle
   // pulse_at while busy.
   task automatic run_op(input logic [W-1:0] n1, input logic [W-1:0] n2, input int pulse_at,
                         output int lat, output int k, output int multi,
                         output logic [2*W-1:0] prod, output logic busy_ok);
      num_1 = n1;
      num_2 = n2;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);          // accepting edge
      @(negedge clk);
      start   = 1'b0;
      lat     = 0;
      k       = 0;
      multi   = 0;
      busy_ok = 1'b1;
      prod    = '0;
      while (!done && lat < MAX_CYC) begin
         if (!busy) busy_ok = 1'b0;
         if (add_M || subs_M) k++;
         if (int'(add_M) + int'(subs_M) + int'(shift_all) > 1) multi++;
         start = (lat == pulse_at);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      if (done) begin
         if (!busy) busy_ok = 1'b0;
         prod = {reg_a, reg_q};
      end else begin
         lat = -1;
      end
   endtask

   typedef struct {
      logic [W-1:0]   num1;
      logic [W-1:0]   num2;
      int             exp_lat;
      int             exp_k;
      logic [2*W-1:0] exp_prod;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int             lat, k, multi, cyc, shifts;
      logic [2*W-1:0] prod;
      logic           busy_ok;

      vecs[0] = '{8'd3,   8'd5,   21, 4, 16'h000F};
      vecs[1] = '{8'd7,   8'd0,   17, 0, 16'h0000};
      vecs[2] = '{8'hFD,  8'd4,   19, 2, 16'hFFF4};
      vecs[3] = '{8'd2,   8'hFF,  18, 1, 16'hFFFE};

      reset = 1'b1;
      start = 1'b0;
      num_1 = '0;
      num_2 = '0;
`ifdef BOOTH_DONE_HOLD_EN
      ack = 1'b1;
`endif
      @(negedge clk);
      check("reset_outputs", 32'(all_outs()), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("idle_outputs", 32'(all_outs()), 32'h0);

      // Table-driven multiplies.
      foreach (vecs[i]) begin
         run_op(vecs[i].num1, vecs[i].num2, -1, lat, k, multi, prod, busy_ok);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("v%0d_addsub_count", i), 32'(k), 32'(vecs[i].exp_k));
         check($sformatf("v%0d_product", i), 32'(prod), 32'(vecs[i].exp_prod));
         check($sformatf("v%0d_sign", i), 32'(prod[2*W-1]), 32'(vecs[i].exp_prod[2*W-1]));
         check($sformatf("v%0d_strobe_overlap", i), 32'(multi), 32'd0);
         check($sformatf("v%0d_busy_held", i), 32'(busy_ok), 32'd1);
         @(negedge clk);
         check($sformatf("v%0d_back_idle", i), 32'(all_outs()), 32'h0);
      end

      // start pulsed while busy: no restart, latency unchanged.
      run_op(8'd3, 8'd5, 6, lat, k, multi, prod, busy_ok);
      check("busy_start_latency", 32'(lat), 32'd21);
      check("busy_start_product", 32'(prod), 32'h000F);
      @(negedge clk);
      check("busy_start_idle", 32'(busy), 32'd0);

      // Reset asserted during the 3rd SHIFT.
      num_1 = 8'd3;
      num_2 = 8'd5;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      shifts = 0;
      cyc    = 0;
      while (shifts < 3 && cyc < MAX_CYC) begin
         @(negedge clk);
         cyc++;
         if (shift_all) shifts++;
      end
      check("third_shift_reached", 32'(shifts), 32'd3);
      reset = 1'b1;
      #1;
      check("midop_reset_outputs", 32'(all_outs()), 32'h0);
      check("midop_reset_state", 32'(dut.state_q), 32'(IDLE));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("after_reset_idle", 32'(busy), 32'd0);
      run_op(8'd3, 8'd5, -1, lat, k, multi, prod, busy_ok);
      check("after_reset_latency", 32'(lat), 32'd21);
      check("after_reset_product", 32'(prod), 32'h000F);
      @(negedge clk);

      // start held high through DONE: IDLE for one cycle, then LOAD.
      run_op(8'd7, 8'd0, 200, lat, k, multi, prod, busy_ok);
      start = 1'b1;
      @(negedge clk);
      check("held_start_idle_gap", 32'({busy, load_M}), 32'b00);
      @(negedge clk);
      start = 1'b0;
      check("held_start_reload", 32'({busy, load_M}), 32'b11);
      cyc = 0;
      while (busy && cyc < MAX_CYC) begin
         @(negedge clk);
         cyc++;
      end
      check("held_start_finishes", 32'(busy), 32'd0);

`ifdef BOOTH_DONE_HOLD_EN
      // DONE held until ack.
      ack   = 1'b0;
      num_1 = 8'd3;
      num_2 = 8'd5;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      while (!done && cyc < MAX_CYC) begin
         @(negedge clk);
         cyc++;
      end
      for (int i = 0; i < 5; i++) begin
         check($sformatf("hold_done_c%0d", i), 32'({done, busy}), 32'b11);
         @(negedge clk);
      end
      check("hold_product", 32'({reg_a, reg_q}), 32'h000F);
      ack = 1'b1;
      @(negedge clk);
      check("hold_ack_release", 32'({done, busy}), 32'b00);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
